// File: rtl/vram_tdm_arbiter_pkg.sv
// Shared constants and index helpers for the VRAM time-division arbiter.
package vram_arb_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_WORK  = 1;

    // Slot index width: max(1, clog2(n)).
    function automatic int slot_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Cyclic increment over 0 .. n-1.
    function automatic int cyc_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vram_tdm_arbiter_rr_pick.sv
// Combinational cyclic first-one finder: scans vec_i from start_i upward with wrap.
module rr_pick
    import vram_arb_pkg::*;
#(
    parameter int  N = 2,
    localparam int W = slot_width(N)
) (
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
        idx_o   = '0;
        found_o = 1'b0;
        for (int off = 0; off < N; off++) begin
            for (int k = 0; k < N; k++) begin
                if (!found_o && (k == (int'(start_i) + off) % N) && vec_i[k]) begin
                    found_o = 1'b1;
                    idx_o   = W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/vram_tdm_arbiter.sv
// Time-division arbiter sharing one synchronous single-port VRAM among NPORTS
// clients: slot counter, grant/mem registers and a two-stage read-tag pipeline.
module vram_tdm_arbiter
    import vram_arb_pkg::*;
#(
    parameter int  NPORTS = 2,
    parameter int  AW     = 16,
    parameter int  DW     = 8,
    parameter int  MODE   = MODE_FIXED,
    localparam int SW     = slot_width(NPORTS)
) (
    input  logic                 clk25,
    input  logic                 rst,
    input  logic [NPORTS-1:0]    p_req_i,
    input  logic [NPORTS-1:0]    p_we_i,
    input  logic [NPORTS*AW-1:0] p_addr_i,
    input  logic [NPORTS*DW-1:0] p_wdata_i,
    output logic [NPORTS-1:0]    p_ack_o,
    output logic [NPORTS*DW-1:0] p_rdata_o,
    output logic [NPORTS-1:0]    p_valid_o,
    output logic [SW-1:0]        slot_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [DW-1:0]        mem_wdata_o,
    output logic                 mem_we_o,
    input  logic [DW-1:0]        mem_rdata_i
);

    logic [SW-1:0]        slot_q, slot_d;
    logic [NPORTS-1:0]    ack_q, ack_d;
    logic [NPORTS-1:0]    valid_q, valid_d;
    logic [NPORTS*DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0]        mem_addr_q, mem_addr_d;
    logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
    logic                 mem_we_q, mem_we_d;
    logic                 rd0_vld_q, rd0_vld_d, rd1_vld_q;
    logic [SW-1:0]        rd0_idx_q, rd0_idx_d, rd1_idx_q;

    logic [SW-1:0] pick_idx;
    logic          pick_found;
    logic          own_req;
    logic          grant_vld;
    logic [SW-1:0] grant_idx;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Scanning from the current slot puts the owner first, then s+1, s+2, ...
    rr_pick #(.N(NPORTS)) u_pick (
        .vec_i   (p_req_i),
        .start_i (slot_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        own_req = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if (SW'(k) == slot_q) own_req = p_req_i[k];
        end
    end

    assign grant_vld = (MODE == MODE_WORK) ? pick_found : own_req;
    assign grant_idx = (MODE == MODE_WORK) ? pick_idx   : slot_q;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (SW'(k) == grant_idx) begin
                sel_we    = p_we_i[k];
                sel_addr  = p_addr_i[k*AW +: AW];
                sel_wdata = p_wdata_i[k*DW +: DW];
            end
        end
    end

    always_comb begin
        slot_d      = SW'(cyc_inc(int'(slot_q), NPORTS));
        ack_d       = '0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd0_vld_d   = grant_vld && !sel_we;
        rd0_idx_d   = grant_idx;
        valid_d     = '0;
        rdata_d     = rdata_q;
        for (int k = 0; k < NPORTS; k++) begin
            ack_d[k] = grant_vld && (SW'(k) == grant_idx);
            // The tag in stage 1 lines up with the RAM's registered read data.
            if (rd1_vld_q && (SW'(k) == rd1_idx_q)) begin
                valid_d[k]             = 1'b1;
                rdata_d[k*DW +: DW]    = mem_rdata_i;
            end
        end
        if (grant_vld) begin
            mem_we_d    = sel_we;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            slot_q      <= '0;
            ack_q       <= '0;
            valid_q     <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rd0_vld_q   <= 1'b0;
            rd0_idx_q   <= '0;
            rd1_vld_q   <= 1'b0;
            rd1_idx_q   <= '0;
        end else begin
            slot_q      <= slot_d;
            ack_q       <= ack_d;
            valid_q     <= valid_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            rd0_vld_q   <= rd0_vld_d;
            rd0_idx_q   <= rd0_idx_d;
            rd1_vld_q   <= rd0_vld_q;
            rd1_idx_q   <= rd0_idx_q;
        end
    end

    assign slot_o      = slot_q;
    assign p_ack_o     = ack_q;
    assign p_valid_o   = valid_q;
    assign p_rdata_o   = rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;

endmodule

// File: doc/vram_tdm_arbiter.md
# vram_tdm_arbiter

Parametrised time-division arbiter that shares one synchronous single-port video RAM among NPORTS clients on clk25. It generalises the two-phase CPU/VGA interleave of the current system: a free-running slot counter owns the RAM bus one clk25 cycle per port. It adds a req/ack handshake, per-port registered read data, and an optional work-conserving mode that hands idle slots to other requesters. It sits between the VRAM instance and its clients: VGA scan-out, CPU, and a future blitter.

## Interface
- NPORTS, 2: number of client ports (≥1); port 0 owns slot 0.
- AW, 16: address width.
- DW, 8: data width.
- MODE, 0: 0 = fixed slots (port k only in slot k); 1 = work-conserving (idle slot goes to next requester, cyclic).

- clk25  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- p_req  in  NPORTS  per-port request, held until ack.
- p_we  in  NPORTS  per-port write flag, qualified by p_req.
- p_addr  in  NPORTS*AW  flattened addresses, port k at [k*AW +: AW].
- p_wdata  in  NPORTS*DW  flattened write data.
- p_ack  out  NPORTS  one-cycle grant pulse.
- p_rdata  out  NPORTS*DW  per-port read data, held until that port's next read completes.
- p_valid  out  NPORTS  one-cycle pulse when p_rdata updates.
- slot  out  max(1,clog2(NPORTS))  current slot index.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DW  RAM read data, registered inside RAM, valid one cycle after address.

## Operation
- Slot counter: increments every clk25 and wraps NPORTS-1 → 0. It never stalls.
- Arbitration at each edge, using the current slot value s:
  - Owner s wins if p_req[s] is high.
  - Else, MODE=0: no grant.
  - Else, MODE=1: the winner is the first k with p_req[k] high, scanning s+1, s+2, … cyclically.
- At most one grant per cycle.
- On grant to port w, registered at the same edge:
  - p_ack[w] = 1.
  - mem_addr = p_addr[w], mem_wdata = p_wdata[w], mem_we = p_we[w].
  - If it is a read, tag (w, rd) is pushed into a 2-stage pipeline.
- With no grant: mem_we = 0; mem_addr and mem_wdata hold their last values.
- Read completion: two edges after the grant edge, p_rdata[w] ← mem_rdata and p_valid[w] = 1 for one cycle.
- Writes produce no p_valid.
- Handshake:
  - The client must keep p_req, p_we, p_addr and p_wdata stable until it samples p_ack.
  - If p_req is still high in the cycle after ack, it is a new request.
- NPORTS=1: slot is constantly 0 and port 0 is granted every cycle it requests. MODE is irrelevant.
- Reset, including mid-operation, clears all of the following to 0 and discards any in-flight read:
  - slot, p_ack, p_valid, p_rdata, mem_addr, mem_wdata, mem_we, and the pipeline tags.

## Timing
- Edge E0 samples p_req. p_ack and mem_* are valid after E0.
- The RAM samples at E1. p_rdata/p_valid are valid after E2.
- Read latency: 2 cycles from the ack edge.
- Guaranteed bandwidth: the owner of a slot is served within NPORTS cycles of raising p_req in either mode.
- MODE=1: no port is starved. Worst-case wait ≤ NPORTS cycles, because every port owns a slot.
- Back-to-back reads from different ports complete in grant order, one per cycle.
- Same-cycle read and write to the same address cannot occur (single grant). A read granted after a write returns the new data.

## Structure
- Shared package vram_arb_pkg:
  - MODE_FIXED = 0 and MODE_WORK = 1 constants.
  - A slot-width function max(1,clog2(N)).
  - A cyclic-increment function.
- Sub-module rr_pick: combinational cyclic first-one finder over NPORTS bits from a start index. It returns the index and a found flag and is reusable elsewhere.
- The top level holds the slot counter, the grant/mem registers, and the 2-deep read-tag pipeline.

## Test plan
- NPORTS=2, MODE=0: port 1 read at 0x1234 in slot 0. Expect:
  - No grant until slot 1.
  - p_ack[1] pulse, mem_addr=0x1234.
  - p_valid[1] 2 cycles later with the RAM model's byte.
- MODE=0: ports 0 and 1 both request continuously. Expect acks to alternate 0,1,0,1 and mem_we only on write-flagged grants.
- NPORTS=3, MODE=1: only port 2 requests reads of 0x0000–0x0003. Expect a grant every cycle regardless of slot and 4 p_valid[2] pulses in order.
- NPORTS=3, MODE=1: all ports request. Expect each slot served to its owner. Then port 0 idles in slot 0 while ports 1 and 2 request: the slot goes to port 1.
- Write 0xA5 to 0x00FF via port 0, then read it back via port 1. Expect p_rdata[1]=0xA5.
- Assert rst one cycle after a read ack. Expect no p_valid, all outputs 0, and slot 0 after release.
